// File: rtl/s2p_if.sv
// Valid/ready bundle for the serial-to-parallel receiver: a one-bit serial
// stream in and an N-bit parallel word out.
interface s2p_if #(
  parameter int N = 8
);
  logic         ser_data;
  logic         ser_valid;
  logic         ser_ready;
  logic [N-1:0] par_data;
  logic         par_valid;
  logic         par_ready;
  logic         par_err;

  modport slave (
    input  ser_data, ser_valid, par_ready,
    output ser_ready, par_data, par_valid, par_err
  );

  modport master (
    output ser_data, ser_valid, par_ready,
    input  ser_ready, par_data, par_valid, par_err
  );
endinterface

// File: rtl/s2p.sv
// Serial-to-parallel receiver with a one-deep output register.
// Define S2P_PARITY_EN to expect an even-parity bit after each word.
module s2p #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  s2p_if.slave bus
);
  localparam int CW = $clog2(N + 1);
`ifdef S2P_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  par_data_q, par_data_d;
  logic          par_valid_q, par_valid_d;
  logic          ser_fire, par_fire, last_bit;
  logic [N-1:0]  shifted, word;
  logic          err_c;
  logic          par_err_q, par_err_d;
  logic          hold_err_q, hold_err_d;

  assign bus.ser_ready = (state_q == COLLECT) && !rst;
  assign bus.par_data  = par_data_q;
  assign bus.par_valid = par_valid_q;

  assign ser_fire = bus.ser_valid && bus.ser_ready;
  assign par_fire = par_valid_q && bus.par_ready;
  assign last_bit = (count_q == LAST);
  assign shifted  = {bus.ser_data, shift_q[N-1:1]};

`ifdef S2P_PARITY_EN
  // The final serial bit is parity only; the data is already in shift_q.
  assign word  = shift_q;
  assign err_c = ^{shift_q, bus.ser_data};
  assign bus.par_err = par_err_q;
`else
  assign word  = shifted;
  assign err_c = 1'b0;
  assign bus.par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      shift_q     <= '0;
      par_data_q  <= '0;
      par_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      par_data_q  <= par_data_d;
      par_valid_q <= par_valid_d;
      par_err_q   <= par_err_d;
      hold_err_q  <= hold_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    par_data_d  = par_data_q;
    par_valid_d = par_valid_q && !par_fire;
    par_err_d   = par_err_q;
    hold_err_d  = hold_err_q;
    case (state_q)
      COLLECT: begin
        if (ser_fire) begin
          if (last_bit) begin
            count_d = '0;
            // Output register is free if empty or being drained this cycle.
            if (!par_valid_q || bus.par_ready) begin
              par_data_d  = word;
              par_err_d   = err_c;
              par_valid_d = 1'b1;
            end else begin
              state_d    = HOLD;
              shift_d    = word;
              hold_err_d = err_c;
            end
          end else begin
            count_d = count_q + CW'(1);
            shift_d = shifted;
          end
        end
      end
      HOLD: begin
        if (par_fire) begin
          par_data_d  = shift_q;
          par_err_d   = hold_err_q;
          par_valid_d = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end
endmodule

// File: tb/tb_s2p.sv
// Directed bench for s2p: reset, streaming, backpressure/HOLD, serial gaps,
// mid-word reset, simultaneous load/drain and (when enabled) parity.
module tb_s2p;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  s2p_if #(.N(8)) bus ();
  s2p #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends one word LSB first, plus its parity bit when parity is enabled.
  task automatic send_word(input logic [7:0] w, input bit gap, input bit flip, input bit rdy_last);
    int nb;
    logic [8:0] bits;
    bits = {(^w) ^ flip, w};
`ifdef S2P_PARITY_EN
    nb = 9;
`else
    nb = 8;
`endif
    for (int i = 0; i < nb; i++) begin
      if (gap && i != 0) begin
        bus.ser_valid = 1'b0;
        cyc();
      end
      if (rdy_last && i == nb - 1) bus.par_ready = 1'b1;
      bus.ser_valid = 1'b1;
      bus.ser_data  = bits[i];
      cyc();
    end
    bus.ser_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] w5a;
    rst = 1'b1;
    bus.ser_valid = 1'b0;
    bus.ser_data  = 1'b0;
    bus.par_ready = 1'b0;
    cyc();
    chk("rst_ser_ready", 16'(bus.ser_ready), 16'h0);
    chk("rst_par_valid", 16'(bus.par_valid), 16'h0);
    chk("rst_par_data",  16'(bus.par_data),  16'h00);
    chk("rst_par_err",   16'(bus.par_err),   16'h0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ser_ready", 16'(bus.ser_ready), 16'h1);

    // Streaming with par_ready high
    bus.par_ready = 1'b1;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_valid", 16'(bus.par_valid), 16'h1);
    chk("a5_data",  16'(bus.par_data),  16'hA5);
    chk("a5_err",   16'(bus.par_err),   16'h0);
    cyc();
    chk("a5_one_cycle", 16'(bus.par_valid), 16'h0);

    // Backpressure into HOLD
    bus.par_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("3c_valid", 16'(bus.par_valid), 16'h1);
    chk("3c_data",  16'(bus.par_data),  16'h3C);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("hold_ser_ready", 16'(bus.ser_ready), 16'h0);
    chk("hold_data",      16'(bus.par_data),  16'h3C);
    cyc();
    chk("hold_stable_data",  16'(bus.par_data),  16'h3C);
    chk("hold_stable_valid", 16'(bus.par_valid), 16'h1);
    bus.par_ready = 1'b1;
    cyc();
    chk("c3_data",      16'(bus.par_data),  16'hC3);
    chk("c3_valid",     16'(bus.par_valid), 16'h1);
    chk("c3_ser_ready", 16'(bus.ser_ready), 16'h1);
    cyc();
    chk("c3_drained", 16'(bus.par_valid), 16'h0);

    // Serial gaps every other cycle
    send_word(8'h01, 1'b1, 1'b0, 1'b0);
    chk("gap01_valid", 16'(bus.par_valid), 16'h1);
    chk("gap01_data",  16'(bus.par_data),  16'h01);
    send_word(8'h80, 1'b1, 1'b0, 1'b0);
    chk("gap80_valid", 16'(bus.par_valid), 16'h1);
    chk("gap80_data",  16'(bus.par_data),  16'h80);
    send_word(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("gapff_valid", 16'(bus.par_valid), 16'h1);
    chk("gapff_data",  16'(bus.par_data),  16'hFF);

    // Reset mid-word discards partial bits
    w5a = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_data  = w5a[i];
      cyc();
    end
    bus.ser_valid = 1'b0;
    chk("partial_no_valid", 16'(bus.par_valid), 16'h0);
    rst = 1'b1;
    cyc();
    chk("midrst_ser_ready", 16'(bus.ser_ready), 16'h0);
    chk("midrst_valid",     16'(bus.par_valid), 16'h0);
    rst = 1'b0;
    send_word(8'h69, 1'b0, 1'b0, 1'b0);
    chk("69_valid", 16'(bus.par_valid), 16'h1);
    chk("69_data",  16'(bus.par_data),  16'h69);
    cyc();

    // Last bit accepted while pending word is consumed
    bus.par_ready = 1'b0;
    send_word(8'h34, 1'b0, 1'b0, 1'b0);
    chk("34_data", 16'(bus.par_data), 16'h34);
    send_word(8'h12, 1'b0, 1'b0, 1'b1);
    chk("swap_data",      16'(bus.par_data),  16'h12);
    chk("swap_valid",     16'(bus.par_valid), 16'h1);
    chk("swap_ser_ready", 16'(bus.ser_ready), 16'h1);
    cyc();
    chk("swap_drained", 16'(bus.par_valid), 16'h0);

`ifdef S2P_PARITY_EN
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("par0f_data", 16'(bus.par_data), 16'h0F);
    chk("par0f_err",  16'(bus.par_err),  16'h0);
    send_word(8'h07, 1'b0, 1'b1, 1'b0);
    chk("par07_data", 16'(bus.par_data), 16'h07);
    chk("par07_err",  16'(bus.par_err),  16'h1);
`else
    send_word(8'h07, 1'b0, 1'b0, 1'b0);
    chk("noparity_data", 16'(bus.par_data), 16'h07);
    chk("noparity_err",  16'(bus.par_err),  16'h0);
`endif
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
